// File: rtl/sqrt_arb_pkg.sv
// Shared types and constants for the square-root arbiter slice: FSM encoding,
// default sizing and the fixed requester index assignment.
package sqrt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int DEF_NREQ  = 3;
    localparam int DEF_NBITS = 21;

    // Per-frame requesters sit at low indices so fixed priority favours them.
    localparam int REQ_AD   = 0;
    localparam int REQ_BC   = 1;
    localparam int REQ_ITER = 2;

endpackage

// File: rtl/sqrt_arbiter_if.sv
// Requester-side bus of the square-root arbiter, with master (requesters)
// and slave (arbiter) views.
interface sqrt_arbiter_if import sqrt_arb_pkg::*; #(
    parameter int NREQ  = DEF_NREQ,
    parameter int NBITS = DEF_NBITS
);
    localparam int MBITS = (NBITS + 1) / 2;

    // req[i] is a one-cycle pulse with no ready: the arbiter always absorbs
    // it into slot i (overwriting). resp_valid is a one-hot single-cycle pulse
    // with no backpressure; resp_data holds until the next response.
    logic [NREQ-1:0]       req;
    logic [NREQ*NBITS-1:0] req_data;
    logic [NREQ-1:0]       pending;
    logic                  busy;
    logic [NREQ-1:0]       resp_valid;
    logic [MBITS-1:0]      resp_data;
    state_t                dbg_state;

    modport master (
        output req, req_data,
        input  pending, busy, resp_valid, resp_data, dbg_state
    );

    modport slave (
        input  req, req_data,
        output pending, busy, resp_valid, resp_data, dbg_state
    );

endinterface

// File: rtl/sqrt_iter.sv
// Bit-serial floor square root: after a start pulse it resolves one result
// bit per cycle, MSB first, for exactly MBITS cycles.
module sqrt_iter #(
    parameter int NBITS = 21
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    input  logic [NBITS-1:0]             i_operand,
    output logic [(NBITS+1)/2-1:0]       o_root_nxt,
    output logic                         o_last
);
    localparam int MBITS = (NBITS + 1) / 2;
    localparam int BW    = (MBITS > 1) ? $clog2(MBITS) : 1;

    logic               r_run;
    logic [BW-1:0]      r_bit;
    logic [MBITS-1:0]   r_ans;
    logic [NBITS-1:0]   r_op;

    logic [MBITS-1:0]   w_trial;
    logic [2*MBITS-1:0] w_trial_ext;
    logic [2*MBITS-1:0] w_sq;
    logic [2*MBITS-1:0] w_op_ext;

    // Square and compare at full 2*MBITS width so no operand bit is lost.
    assign w_trial     = r_ans | (MBITS'(1) << r_bit);
    assign w_trial_ext = (2*MBITS)'(w_trial);
    assign w_sq        = w_trial_ext * w_trial_ext;
    assign w_op_ext    = (2*MBITS)'(r_op);
    assign o_root_nxt  = (w_sq <= w_op_ext) ? w_trial : r_ans;
    assign o_last      = r_run && (r_bit == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
            r_bit <= '0;
            r_ans <= '0;
            r_op  <= '0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_bit <= BW'(MBITS - 1);
            r_ans <= '0;
            r_op  <= i_operand;
        end else if (r_run) begin
            r_ans <= o_root_nxt;
            if (r_bit == '0) begin
                r_run <= 1'b0;
            end else begin
                r_bit <= r_bit - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one bit-serial square-root unit among NREQ requesters with one
// buffered slot each. SQRT_ARB_RR_EN selects round-robin; otherwise fixed priority.
module sqrt_arbiter import sqrt_arb_pkg::*; #(
    parameter int NREQ  = DEF_NREQ,
    parameter int NBITS = DEF_NBITS
) (
    input  logic          clk,
    input  logic          rst_n,
    sqrt_arbiter_if.slave bus
);
    localparam int MBITS = (NBITS + 1) / 2;
    localparam int IW    = $clog2(NREQ);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NREQ-1:0]   r_pending;
    logic [NBITS-1:0]  r_slot [NREQ];
    logic [IW-1:0]     r_winner;
    logic [NBITS-1:0]  r_operand;
    logic [MBITS-1:0]  r_resp_data;

    logic [IW-1:0]     w_pick;
    logic              w_pick_vld;
    logic              w_grant;
    logic              w_start;
    logic              w_busy;
    logic [NREQ-1:0]   w_resp_valid;
    logic [MBITS-1:0]  w_root_nxt;
    logic              w_last;

`ifdef SQRT_ARB_RR_EN
    logic [IW-1:0]     r_last_grant;

    // Walk from the farthest candidate to the nearest so the one right after
    // the last grant is written last and wins.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (r_pending[IW'((int'(r_last_grant) + k) % NREQ)]) begin
                w_pick_vld = 1'b1;
                w_pick     = IW'((int'(r_last_grant) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= IW'(NREQ - 1);
        end else if (w_grant) begin
            r_last_grant <= w_pick;
        end
    end
`else
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_pick_vld = 1'b1;
                w_pick     = IW'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pick_vld) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_grant      = (r_state == IDLE) && w_pick_vld;
        w_start      = (r_state == LOAD);
        w_busy       = (r_state != IDLE);
        w_resp_valid = (r_state == RESP) ? (NREQ'(1) << r_winner) : '0;
    end

    // A new pulse beats a same-cycle grant: the slot keeps pending with the
    // new data while the grant carries the previously buffered operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req[i]) begin
                    r_pending[i] <= 1'b1;
                    r_slot[i]    <= bus.req_data[i*NBITS +: NBITS];
                end else if (w_grant && (w_pick == IW'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_winner    <= '0;
            r_operand   <= '0;
            r_resp_data <= '0;
        end else begin
            if (w_grant) begin
                r_winner  <= w_pick;
                r_operand <= r_slot[w_pick];
            end
            if ((r_state == RUN) && w_last) begin
                r_resp_data <= w_root_nxt;
            end
        end
    end

    sqrt_iter #(.NBITS(NBITS)) u_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_start),
        .i_operand  (r_operand),
        .o_root_nxt (w_root_nxt),
        .o_last     (w_last)
    );

    assign bus.pending    = r_pending;
    assign bus.busy       = w_busy;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter: responses are predicted into a queue at
// stimulus time and checked by a negedge monitor (owner, root, cycle).
`timescale 1ns/1ps
module tb_sqrt_arbiter;
    import sqrt_arb_pkg::*;

    localparam int NREQ  = 3;
    localparam int NBITS = 21;
    localparam int MBITS = 11;
    localparam int W     = NREQ + MBITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   c;
    int   n;
    int   errors = 0;
    int   checks = 0;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [W-1:0] mon_e;
    int           mon_ec;

    logic [NBITS-1:0] bnd_val  [5] = '{21'd0, 21'd1, 21'd24, 21'd2097151, 21'd1048576};
    logic [MBITS-1:0] bnd_root [5] = '{11'd0, 11'd1, 11'd4, 11'd1448, 11'd1024};
    logic [NBITS-1:0] rep_val  [3] = '{21'd9, 21'd16, 21'd36};
    logic [NBITS-1:0] rnd;
    int               rnd_idx;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sqrt_arbiter_if #(.NREQ(NREQ), .NBITS(NBITS)) bus ();

    sqrt_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [MBITS-1:0] model_sqrt(input logic [NBITS-1:0] x);
        longint r = 0;
        while ((r + 1) * (r + 1) <= longint'(x)) r++;
        return MBITS'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int owner, input logic [MBITS-1:0] root, input int ecyc);
        exp_q.push_back({NREQ'(1) << owner, root});
        exp_cyc_q.push_back(ecyc);
    endtask

    task automatic drive(input logic [NREQ-1:0] mask, input logic [NBITS-1:0] d0,
                         input logic [NBITS-1:0] d1, input logic [NBITS-1:0] d2);
        bus.req      = mask;
        bus.req_data = {d2, d1, d0};
        @(negedge clk);
        bus.req      = '0;
    endtask

    task automatic drive1(input int idx, input logic [NBITS-1:0] v);
        drive(NREQ'(1) << idx, v, v, v);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((bus.busy || bus.pending != '0 || exp_q.size() != 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        checks++;
        assert (k < 400) else begin
            errors++;
            $error("FAIL %s_timeout waited=%0d limit=400", tag, k);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (bus.resp_valid != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_resp observed valid=%b data=%0d expected=none",
                       bus.resp_valid, bus.resp_data);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_ec = exp_cyc_q.pop_front();
                checks++;
                assert (bus.resp_valid === mon_e[W-1:MBITS]) else begin
                    errors++;
                    $error("FAIL resp_owner observed=%b expected=%b", bus.resp_valid, mon_e[W-1:MBITS]);
                end
                checks++;
                assert (bus.resp_data === mon_e[MBITS-1:0]) else begin
                    errors++;
                    $error("FAIL resp_data observed=%0d expected=%0d", bus.resp_data, mon_e[MBITS-1:0]);
                end
                if (mon_ec >= 0) begin
                    checks++;
                    assert (cyc === mon_ec) else begin
                        errors++;
                        $error("FAIL resp_cycle observed=%0d expected=%0d", cyc, mon_ec);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_pending", bus.pending, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_state", bus.dbg_state, IDLE);

        // Single request: 25 -> 5, 14 cycles after the request edge
        c = cyc;
        push(0, 11'd5, c + 14);
        drive1(0, 21'd25);
        check("single_pending_e1", bus.pending, 3'b001);
        check("single_busy_e1", bus.busy, 0);
        @(negedge clk);
        check("single_pending_e2", bus.pending, 3'b000);
        check("single_busy_e2", bus.busy, 1);
        check("single_state_e2", bus.dbg_state, LOAD);
        wait_idle("single");

        // Boundary radicands
        for (int k = 0; k < 5; k++) begin
            c = cyc;
            push(k % NREQ, bnd_root[k], c + 14);
            drive1(k % NREQ, bnd_val[k]);
            wait_idle("boundary");
        end

        // Random radicands on random requesters
        for (int k = 0; k < 6; k++) begin
            rnd     = NBITS'($urandom_range(0, (1 << NBITS) - 1));
            rnd_idx = $urandom_range(0, NREQ - 1);
            c = cyc;
            push(rnd_idx, model_sqrt(rnd), c + 14);
            drive1(rnd_idx, rnd);
            wait_idle("random");
        end

        // Contention, then re-pulse 2 and 0 while owner 2 runs: 0 goes first
        do_reset();
        c = cyc;
        push(0, 11'd3, c + 14);
        push(1, 11'd4, c + 28);
        push(2, 11'd10, c + 42);
        drive(3'b111, 21'd9, 21'd16, 21'd100);
        wait_until(c + 32);
        drive1(2, 21'd144);
        wait_until(c + 35);
        drive1(0, 21'd225);
        push(0, 11'd15, c + 56);
        push(2, 11'd12, c + 70);
        wait_idle("contention");

        // Requester 0 re-requests on each of its responses
        do_reset();
`ifdef SQRT_ARB_RR_EN
        push(0, 11'd2, -1);
        push(2, 11'd20, -1);
        push(0, 11'd3, -1);
        push(0, 11'd4, -1);
        push(0, 11'd6, -1);
`else
        push(0, 11'd2, -1);
        push(0, 11'd3, -1);
        push(0, 11'd4, -1);
        push(0, 11'd6, -1);
        push(2, 11'd20, -1);
`endif
        drive(3'b101, 21'd4, 21'd0, 21'd400);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!bus.resp_valid[0] && n < 100) begin
                @(negedge clk);
                n++;
            end
            checks++;
            assert (n < 100) else begin
                errors++;
                $error("FAIL starve_wait observed=%0d expected=below_100", n);
            end
            drive1(0, rep_val[k]);
        end
        wait_idle("starve");

        // Overwrite while another requester is served
        c = cyc;
        push(0, 11'd100, c + 14);
        drive1(0, 21'd10000);
        wait_until(c + 5);
        drive1(1, 21'd49);
        wait_until(c + 8);
        drive1(1, 21'd64);
        check("overwrite_pending", bus.pending, 3'b010);
        push(1, 11'd8, c + 28);
        wait_idle("overwrite");

        // Pulse coinciding with its own grant: old operand served first
        c = cyc;
        push(1, 11'd11, c + 14);
        push(1, 11'd13, c + 28);
        drive1(1, 21'd121);
        drive1(1, 21'd169);
        check("collide_pending", bus.pending, 3'b010);
        check("collide_busy", bus.busy, 1);
        wait_idle("collide");

        // Reset in the sixth RUN cycle discards the operation
        c = cyc;
        drive1(1, 21'd1000);
        wait_until(c + 8);
        check("midrun_state", bus.dbg_state, RUN);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_pending", bus.pending, 0);
        check("midrun_rst_busy", bus.busy, 0);
        check("midrun_rst_resp_valid", bus.resp_valid, 0);
        check("midrun_rst_resp_data", bus.resp_data, 0);
        check("midrun_rst_state", bus.dbg_state, IDLE);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", bus.busy, 0);
        c = cyc;
        push(2, 11'd9, c + 14);
        drive1(2, 21'd81);
        wait_idle("post_reset");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
